// File: rtl/gray_counter.sv
// Prescaled up/down Gray-code counter with parallel load and registered binary/Gray outputs.
// Optional sticky single-bit-change checker is enabled by defining GRAY_CHECK_EN.
module gray_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             step,
    output logic             wrap
`ifdef GRAY_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PreLast = PW'(DIV - 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             is_step;

    always_comb begin
        bin_d   = bin_q;
        pre_d   = pre_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        is_step = 1'b0;
        if (load) begin
            bin_d = din;
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PreLast) begin
                is_step = 1'b1;
                pre_d   = '0;
                bin_d   = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
                step_d  = 1'b1;
                wrap_d  = up ? (&bin_q) : ~(|bin_q);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            pre_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            pre_q  <= pre_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef GRAY_CHECK_EN
    // gray_q still holds the pre-step code, so the step's bit flips are gray_q ^ gray_d.
    logic [WIDTH-1:0] gray_diff;
    logic             one_flip;
    logic             err_q;

    always_comb begin
        gray_diff = gray_q ^ gray_d;
        one_flip  = (gray_diff != '0) && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (is_step && !one_flip) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign bin  = bin_q;
    assign gray = gray_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised Gray-code counter with a registered binary/Gray output pair. It is the sequential successor to the 4-bit combinational binary-to-Gray converter. It counts up or down at a programmable prescaled rate, accepts a parallel binary load, and flags wrap-around. It drives board LEDs or any downstream logic that needs a single-bit-change sequence.

## Interface
- `WIDTH`, 4: counter width in bits; ≥ 2.
- `DIV`, 1: enabled cycles per count step; ≥ 1. Prescaler width is `$clog2(DIV)`, minimum 1.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: count enable; advances the prescaler.
- `up` in 1: direction; 1 = increment, 0 = decrement. Sampled on step cycles only.
- `load` in 1: parallel load strobe.
- `din` in WIDTH: binary load value.
- `bin` out WIDTH: registered binary count.
- `gray` out WIDTH: registered Gray count; always equals `bin ^ (bin >> 1)`.
- `step` out 1: one-cycle pulse, high in the cycle after the count changed by a step.
- `wrap` out 1: one-cycle pulse, high in the cycle after a step crossed the all-ones/zero boundary.
- `err` out 1: sticky Gray-distance error; present only with `GRAY_CHECK_EN`.

## Operation
- **State:** `bin`, `gray`, prescaler `pre`, `step`, `wrap`, and `err` when configured.
- **Reset (`rst`=1):** `bin`=0, `gray`=0, `pre`=0, `step`=0, `wrap`=0, `err`=0. Reset overrides every other input.
- **Priority per cycle:** `rst` > `load` > `en`.
- **Load (`load`=1):**
  - `bin`←`din`, `gray`←`din ^ (din >> 1)`, `pre`←0.
  - `step`=0 and `wrap`=0 in the next cycle; `en` is ignored that cycle.
- **Enabled, prescaler not expired (`en`=1, `pre` ≠ DIV−1):** `pre`←`pre`+1; count holds; `step`=0.
- **Enabled, prescaler expired (`en`=1, `pre` = DIV−1):** this is a step.
  - `pre`←0.
  - `bin`←`bin`±1 modulo 2^WIDTH; `gray` is recomputed from the new `bin`.
  - `step`←1.
  - `wrap`←1 if counting up from 2^WIDTH−1 to 0, or down from 0 to 2^WIDTH−1.
- **Idle (`en`=0):** count and `pre` hold; `step`=0, `wrap`=0.
- **DIV=1:** every enabled cycle is a step.
- **Arithmetic:** unsigned, width exactly WIDTH; overflow discarded (natural wrap).
- **No FSM beyond the prescaler:** the block is a counter plus output registers.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Latency is 1 cycle: an input sampled at edge k appears on outputs after edge k.
- `step` and `wrap` are high for exactly one cycle, aligned with the new `bin`/`gray` value.
- Direction change takes effect on the next step without a dead cycle.
- `load` and a step in the same cycle: the load wins; no step pulse; prescaler restarts at 0.
- Reset mid-count: all outputs are 0 after the reset edge; counting resumes at the first enabled cycle after `rst` falls.

## Configuration
- **`GRAY_CHECK_EN` defined:**
  - The block keeps the previous `gray` value.
  - After any step, if the Hamming distance between old and new `gray` ≠ 1, `err` sets.
  - `err` is sticky until `rst`.
  - Loads are excluded from the check.
- **`GRAY_CHECK_EN` undefined:** the `err` port and its checker logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `en`=1, `load`=1 → `bin`=0, `gray`=0, `step`=0, `wrap`=0.
- **Up count, WIDTH=4, DIV=1, `en`=1, `up`=1, 16 cycles:**
  - `gray` sequence is 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - `wrap` pulses only on the 0000 cycle.
- **Down count from 0, `up`=0, one step:** `bin`=1111, `gray`=1000, `wrap`=1 for one cycle.
- **Load:** `load`=1, `din`=1010 → next cycle `bin`=1010, `gray`=1111, `step`=0.
- **Load with `en`=1 in the same cycle:** the load wins; no step pulse.
- **DIV=3:** `en` toggles 1,1,0,1 → the count advances only after the third enabled cycle; `step` pulses once.
- **`GRAY_CHECK_EN`:** run a full up and down sweep with interleaved loads → `err` stays 0 throughout.
